// File: rtl/pix_dot_sum.sv
// Pipelined signed sum of NCH fixed-point channel products plus offset, clamped
// to an OW-bit pixel with a saturation flag, valid/ready stall and event counter.

module pix_dot_term #(
    parameter int PW    = 36,
    parameter int FRAC  = 9,
    parameter int ROUND = 1,
    parameter int AW    = 32
) (
    input  logic [PW-1:0]        i_p,
    output logic signed [AW-1:0] o_term
);
    localparam logic [PW:0] RC = (ROUND != 0) ? ((PW+1)'(1) << (FRAC-1)) : '0;

    // One guard bit so the rounding constant cannot wrap the product.
    logic signed [PW:0] w_ext;

    assign w_ext  = $signed({i_p[PW-1], i_p} + RC);
    assign o_term = AW'(w_ext >>> FRAC);
endmodule

module pix_dot_sum #(
    parameter int NCH        = 3,
    parameter int PW         = 36,
    parameter int FRAC       = 9,
    parameter int OW         = 8,
    parameter int OUT_SIGNED = 0,
    parameter int ROUND      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*PW-1:0] prod,
    input  logic [OW:0]       offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OW-1:0]     result,
    output logic              sat,
    output logic [15:0]       sat_cnt,
    input  logic              cnt_clr
);
    localparam int TW = PW - FRAC;
    localparam int D  = $clog2(NCH + 1);
    localparam int AW = ((TW > OW + 1) ? TW : OW + 1) + D + 1;

    localparam logic signed [AW-1:0] HI = (OUT_SIGNED != 0) ?
        AW'((longint'(1) <<< (OW - 1)) - 1) : AW'((longint'(1) <<< OW) - 1);
    localparam logic signed [AW-1:0] LO = (OUT_SIGNED != 0) ?
        AW'(-(longint'(1) <<< (OW - 1))) : '0;

    // Operand count feeding tree level l (level 0 is the E stage).
    function automatic int lvl_n(input int l);
        int n;
        n = NCH + 1;
        for (int i = 0; i < l; i++) n = (n + 1) / 2;
        return n;
    endfunction

    logic                 w_en;
    logic [D+1:0]         r_vld_pipe;
    logic signed [AW-1:0] w_term [NCH];
    logic signed [AW-1:0] w_off;
    logic signed [AW-1:0] r_lvl [D+1][NCH+1];
    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] w_clamp;
    logic [OW-1:0]        r_result;
    logic                 r_sat;
    logic [15:0]          r_sat_cnt;

    assign w_en      = !r_vld_pipe[D+1] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_vld_pipe[D+1];
    assign result    = r_result;
    assign sat       = r_sat;
    assign sat_cnt   = r_sat_cnt;
    assign w_off     = {{(AW-OW-1){offset[OW]}}, offset};

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        pix_dot_term #(.PW(PW), .FRAC(FRAC), .ROUND(ROUND), .AW(AW)) u_term (
            .i_p   (prod[i*PW +: PW]),
            .o_term(w_term[i])
        );
    end

    // Bubbles travel with the data; nothing is compressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_vld_pipe <= '0;
        else if (w_en) r_vld_pipe <= {r_vld_pipe[D:0], in_valid};
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int j = 0; j < NCH; j++) r_lvl[0][j] <= w_term[j];
            r_lvl[0][NCH] <= w_off;
            for (int lv = 1; lv <= D; lv++) begin
                for (int j = 0; j <= NCH; j++) begin
                    if (j < lvl_n(lv)) begin
                        if (2*j + 1 < lvl_n(lv - 1))
                            r_lvl[lv][j] <= r_lvl[lv-1][(2*j > NCH) ? NCH : 2*j]
                                          + r_lvl[lv-1][(2*j+1 > NCH) ? NCH : 2*j+1];
                        else
                            r_lvl[lv][j] <= r_lvl[lv-1][(2*j > NCH) ? NCH : 2*j];
                    end else begin
                        r_lvl[lv][j] <= '0;
                    end
                end
            end
        end
    end

    assign w_sum = r_lvl[D][0];

    always_comb begin
        w_clamp = w_sum;
        if (w_sum > HI)      w_clamp = HI;
        else if (w_sum < LO) w_clamp = LO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_sat    <= 1'b0;
        end else if (w_en && r_vld_pipe[D]) begin
            r_result <= OW'(w_clamp);
            r_sat    <= (w_clamp != w_sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat_cnt <= '0;
        else if (cnt_clr)
            r_sat_cnt <= '0;
        else if (r_vld_pipe[D+1] && out_ready && r_sat && r_sat_cnt != 16'hFFFF)
            r_sat_cnt <= r_sat_cnt + 16'd1;
    end
endmodule

// File: tb/tb_pix_dot_sum.sv
// Bench for pix_dot_sum: five parameter variants share one stimulus stream and
// are each scoreboarded against an arithmetic model of the pixel sum.

module tb_pix_dot_sum;
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
    logic [7:0][35:0] prod_all = '0;
    logic [9:0] offset_all = '0;

    logic ov [5];
    logic ir [5];
    logic sat_o [5];
    logic [15:0] sc [5];
    logic [7:0] res0, res1, res3, res4;
    logic [8:0] res2;
    int resv [5];

    int nch_a [5] = '{3, 3, 3, 1, 8};
    int rnd_a [5] = '{1, 0, 1, 1, 1};
    int os_a  [5] = '{0, 0, 1, 0, 0};
    int ow_a  [5] = '{8, 8, 9, 8, 8};

    int nchk = 0, nfail = 0;
    int q [5][$];
    int mcnt [5];
    bit pst [5];
    int pres [5];
    int outcnt0 = 0;
    int f_lat [5], f_res [5], f_sat [5];

    always #5 clk = ~clk;

    always_comb begin
        resv[0] = int'(res0); resv[1] = int'(res1); resv[2] = int'(res2);
        resv[3] = int'(res3); resv[4] = int'(res4);
    end

    pix_dot_sum #(.NCH(3)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .prod(prod_all[2:0]), .offset(offset_all[8:0]), .out_valid(ov[0]), .out_ready(out_ready),
        .result(res0), .sat(sat_o[0]), .sat_cnt(sc[0]), .cnt_clr(cnt_clr));
    pix_dot_sum #(.NCH(3), .ROUND(0)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .prod(prod_all[2:0]), .offset(offset_all[8:0]), .out_valid(ov[1]), .out_ready(out_ready),
        .result(res1), .sat(sat_o[1]), .sat_cnt(sc[1]), .cnt_clr(cnt_clr));
    pix_dot_sum #(.NCH(3), .OW(9), .OUT_SIGNED(1)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(ir[2]), .prod(prod_all[2:0]), .offset(offset_all), .out_valid(ov[2]),
        .out_ready(out_ready), .result(res2), .sat(sat_o[2]), .sat_cnt(sc[2]), .cnt_clr(cnt_clr));
    pix_dot_sum #(.NCH(1)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
        .prod(prod_all[0]), .offset(offset_all[8:0]), .out_valid(ov[3]), .out_ready(out_ready),
        .result(res3), .sat(sat_o[3]), .sat_cnt(sc[3]), .cnt_clr(cnt_clr));
    pix_dot_sum #(.NCH(8)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[4]),
        .prod(prod_all), .offset(offset_all[8:0]), .out_valid(ov[4]), .out_ready(out_ready),
        .result(res4), .sat(sat_o[4]), .sat_cnt(sc[4]), .cnt_clr(cnt_clr));

    task automatic check(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Pixel value straight from the arithmetic definition, on 64-bit integers.
    function automatic void model(input int k, output int r, output bit s);
        longint sum, t, o, lo, hi, c;
        o = longint'(offset_all) & ((longint'(1) << (ow_a[k] + 1)) - 1);
        if (o >= (longint'(1) << ow_a[k])) o -= (longint'(1) << (ow_a[k] + 1));
        sum = o;
        for (int ch = 0; ch < nch_a[k]; ch++) begin
            t = longint'(signed'(prod_all[ch]));
            if (rnd_a[k] != 0) t += 256;
            sum += t >>> 9;
        end
        if (os_a[k] != 0) begin
            lo = -(longint'(1) << (ow_a[k] - 1));
            hi = (longint'(1) << (ow_a[k] - 1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) << ow_a[k]) - 1;
        end
        c = (sum < lo) ? lo : (sum > hi) ? hi : sum;
        s = (c != sum);
        r = int'(c & ((longint'(1) << ow_a[k]) - 1));
    endfunction

    function automatic longint rnd_prod();
        logic [35:0] b;
        if ($urandom_range(0, 3) == 0) begin
            b = 36'({$urandom(), $urandom()});
            return longint'(signed'(b));
        end
        return longint'($urandom_range(0, 600*512)) - 300*512;
    endfunction

    task automatic rand_inputs();
        for (int ch = 0; ch < 8; ch++) prod_all[ch] = 36'(rnd_prod());
        offset_all = 10'($urandom_range(0, 1023));
    endtask

    always @(negedge clk) begin : cmp
        int e, r;
        bit s;
        if (!rst_n) begin
            for (int k = 0; k < 5; k++) begin
                q[k].delete(); mcnt[k] = 0; pst[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("u%0d in_ready", k), ir[k], !(ov[k] && !out_ready));
                check($sformatf("u%0d sat_cnt", k), sc[k], mcnt[k]);
                if (pst[k]) begin
                    check($sformatf("u%0d stall out_valid", k), ov[k], 1);
                    check($sformatf("u%0d stall result", k), resv[k], pres[k]);
                end
                if (ov[k] && out_ready) begin
                    if (k == 0) outcnt0++;
                    e = 0;
                    if (q[k].size() == 0) check($sformatf("u%0d spurious out_valid", k), ov[k], 0);
                    else begin
                        e = q[k].pop_front();
                        check($sformatf("u%0d result", k), resv[k], e & 'hFFFF);
                        check($sformatf("u%0d sat", k), sat_o[k], (e >> 16) & 1);
                    end
                    if (cnt_clr) mcnt[k] = 0;
                    else if (((e >> 16) & 1) != 0 && mcnt[k] < 65535) mcnt[k]++;
                end else if (cnt_clr) mcnt[k] = 0;
                if (in_valid && ir[k]) begin
                    model(k, r, s);
                    q[k].push_back(r | (int'(s) << 16));
                end
                pst[k]  = ov[k] && !out_ready;
                pres[k] = resv[k];
            end
        end
    end

    // One isolated transfer; records per-variant latency, result and sat.
    task automatic fire(input longint p0, input longint p1, input longint p2, input int off);
        prod_all = '0;
        prod_all[0] = 36'(p0); prod_all[1] = 36'(p1); prod_all[2] = 36'(p2);
        offset_all = 10'(off);
        in_valid = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) f_lat[k] = 0;
        for (int c = 1; c <= 8; c++) begin
            for (int k = 0; k < 5; k++)
                if (ov[k] && f_lat[k] == 0) begin
                    f_lat[k] = c; f_res[k] = resv[k]; f_sat[k] = int'(sat_o[k]);
                end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_drained(input string nm);
        for (int k = 0; k < 5; k++) check($sformatf("%s u%0d pending", nm, k), q[k].size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, ph, sent;
        bit acc;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset out_valid", ov[0], 0);
        check("reset in_ready", ir[0], 1);
        check("reset result", resv[0], 0);
        check("reset sat", sat_o[0], 0);
        check("reset sat_cnt", sc[0], 0);

        fire(100 << 9, 50 << 9, 25 << 9, 16);
        check("basic latency", f_lat[0], 4);
        check("basic result", f_res[0], 191);
        check("basic sat", f_sat[0], 0);
        check("nch1 latency", f_lat[3], 3);
        check("nch1 result", f_res[3], 116);
        check("nch8 latency", f_lat[4], 6);
        check("nch8 result", f_res[4], 191);

        fire(200 << 9, 200 << 9, 200 << 9, 0);
        check("ovf hi result", f_res[0], 255);
        check("ovf hi sat", f_sat[0], 1);
        check("ovf hi sat_cnt", sc[0], 1);

        fire(-(300 << 9), 0, 0, 16);
        check("ovf lo result", f_res[0], 0);
        check("ovf lo sat", f_sat[0], 1);
        check("ovf lo sat_cnt", sc[0], 2);

        fire(256, 0, 0, 0);
        check("round up result", f_res[0], 1);
        check("floor result", f_res[1], 0);

        fire(-257, 0, 0, 0);
        check("neg round result", f_res[0], 0);
        check("neg round sat", f_sat[0], 1);
        check("signed latency", f_lat[2], 4);
        check("signed result", f_res[2], 511);
        check("signed sat", f_sat[2], 0);

        // Backpressure: out_ready pattern 1,0,0 repeating.
        base = outcnt0; ph = 0; sent = 0;
        rand_inputs();
        while (sent < 10 && ph < 200) begin
            out_ready = (ph % 3 == 0); in_valid = 1'b1;
            #1 acc = ir[0];
            @(posedge clk); #1;
            ph++;
            if (acc) begin sent++; rand_inputs(); end
        end
        in_valid = 1'b0;
        repeat (40) begin out_ready = (ph % 3 == 0); ph++; @(posedge clk); #1; end
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("backpressure sent", sent, 10);
        check("backpressure delivered", outcnt0 - base, 10);
        check_drained("backpressure");

        repeat (400) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            cnt_clr   = ($urandom_range(0, 49) == 0);
            rand_inputs();
            @(posedge clk); #1;
        end
        in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 check_drained("random");

        // Reset with three results in flight.
        out_ready = 1'b1; in_valid = 1'b1;
        repeat (3) begin rand_inputs(); @(posedge clk); #1; end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("midreset u%0d out_valid", k), ov[k], 0);
            check($sformatf("midreset u%0d sat_cnt", k), sc[k], 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        base = outcnt0;
        repeat (10) @(posedge clk);
        #1 check("post reset quiet", outcnt0 - base, 0);
        fire(100 << 9, 50 << 9, 25 << 9, 16);
        check("post reset latency", f_lat[0], 4);
        check("post reset result", f_res[0], 191);

        // Continuous overflow drives sat_cnt into saturation.
        cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        prod_all = '0;
        prod_all[0] = 36'(200 << 9); prod_all[1] = 36'(200 << 9); prod_all[2] = 36'(200 << 9);
        offset_all = '0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (65600) @(posedge clk);
        #1 check("sat_cnt saturated", sc[0], 65535);
        cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        check("clr beats increment", sc[0], 0);
        @(posedge clk); #1;
        check("count after clr", sc[0], 1);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 check_drained("saturate");

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/pix_dot_sum.md
# pix_dot_sum

Parametrised, pipelined signed sum of NCH fixed-point channel products plus a constant offset, producing a clamped pixel value. It sits after the per-channel coefficient multipliers in the colour-conversion path, for example RGB to Y/Cb/Cr. It generalises the fixed three-channel adder: configurable channel count, widths and rounding, full-precision sign handling, output saturation with a flag, a valid/ready handshake with stall, and a saturation-event counter.

## Interface
- NCH, 3, number of product channels (1..8)
- PW, 36, signed product width per channel
- FRAC, 9, fractional bits in each product (1..PW-2)
- OW, 8, output width
- OUT_SIGNED, 0, 0: clamp to [0, 2^OW-1]; 1: clamp to [-2^(OW-1), 2^(OW-1)-1]
- ROUND, 1, 1: round half up before summing; 0: floor (arithmetic shift)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  products and offset valid
- in_ready  out  1  block accepts input this cycle
- prod  in  NCH*PW  packed signed products, channel i at [i*PW +: PW]
- offset  in  OW+1  signed constant added to the sum
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  OW  clamped sum
- sat  out  1  result was clamped, qualified by out_valid
- sat_cnt  out  16  saturating count of clamped results delivered
- cnt_clr  in  1  synchronous clear of sat_cnt

## Operation
- Term width TW = PW-FRAC. Stage E, per channel: term_i = (P_i + 2^(FRAC-1)) >>> FRAC when ROUND=1, otherwise P_i >>> FRAC. Computed in PW+1 bits so rounding cannot overflow. Keep the full signed term; no bits are dropped.
- offset is sign-extended to the accumulator width AW = max(TW, OW+1) + clog2(NCH+1) + 1. The sum of NCH terms plus the offset cannot overflow AW.
- Adder tree: NCH+1 operands are added pairwise in D = clog2(NCH+1) registered levels. An odd operand passes through a register.
- Stage S: clamp to the OUT_SIGNED range and register result and sat. sat=1 when the clamped value differs from the full sum.
- The pipeline has E, D tree levels and S. Each stage carries a valid bit.
- Global advance: en = !out_valid || out_ready. in_ready = en (combinational). No stage updates when en=0. Bubbles are not compressed.
- A transfer happens on in_valid && in_ready. Valid bits shift on en, and a bubble (valid 0) enters when there is no transfer.
- sat_cnt increments on out_valid && out_ready && sat and holds at 16'hFFFF. cnt_clr takes priority over the increment.

## Timing
- Latency L = D + 2 cycles from input transfer to out_valid, with no stall. Defaults: D=2, L=4.
- Throughput is one result per cycle while out_ready=1.
- Reset: all valid bits are 0, and result, sat and sat_cnt are 0. in_ready is 1 out of reset. Data registers need not be reset.
- Reset asserted mid-operation discards all in-flight results. out_valid falls asynchronously, and no result emerges after reset is released.
- While out_valid && !out_ready, result and sat hold stable and the whole pipe freezes. The input is not accepted because in_ready=0.
- When out_valid && out_ready and in_valid occur in the same cycle, the input is accepted and the output advances in that cycle.
- When cnt_clr and a saturating transfer occur in the same cycle, sat_cnt becomes 0.

## Test plan
- Defaults. P=(100<<9, 50<<9, 25<<9), offset=16 -> result=191, sat=0, out_valid exactly 4 cycles after the transfer.
- Overflow. P=(200<<9)x3, offset=0 -> result=255, sat=1, sat_cnt=1. P0=-(300<<9), others 0, offset=16 -> result=0, sat=1, sat_cnt=2.
- Rounding. P0=256, others 0, offset=0: ROUND=1 -> 1; ROUND=0 -> 0. P0=-257, ROUND=1 -> -1 in the sum, which clamps to 0 with sat=1. With OUT_SIGNED=1, OW=9 -> -1 and sat=0.
- Backpressure. Stream 10 inputs with out_ready toggling 1,0,0,1,... -> all 10 results arrive in order with none lost or duplicated, result stays stable during stalls, and in_ready = !(out_valid && !out_ready) every cycle.
- Reset mid-stream. Assert rst_n=0 with 3 results in flight -> out_valid=0 immediately, sat_cnt=0, and no output appears until new inputs arrive and L cycles pass.
- Parametrisation. NCH=1 (D=1, L=3) and NCH=8 (D=4, L=6), each with random signed products against a reference model -> bit-exact results and sat flags. sat_cnt saturates at 65535 under forced continuous overflow.
